// File: rtl/pc_next_unit_pkg.sv
// Shared state encoding, default vectors and J-type field width for pc_next_unit.
// Build option: define PC_MISALIGN_TRAP_EN to trap on misaligned register jumps.
package pc_next_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0180;
  localparam int          J_INDEX_W        = 26;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit MISALIGN_TRAP_EN = 1'b1;
`else
  localparam bit MISALIGN_TRAP_EN = 1'b0;
`endif

endpackage

// File: rtl/pc_next_unit_target_calc.sv
// Combinational redirect target selection: jr > jump > branch > sequential.
// With PC_MISALIGN_TRAP_EN a misaligned jr resolves to TRAP_VECTOR and raises jr_trap.
module pc_target_calc
  import pc_next_unit_pkg::*;
#(
  parameter int                  WIDTH_PC    = 32,
  parameter int                  STEP        = 4,
  parameter logic [WIDTH_PC-1:0] TRAP_VECTOR = WIDTH_PC'(TRAP_VECTOR_DEF)
) (
  input  logic [WIDTH_PC-1:0]  pc,
  input  logic                 branch_taken,
  input  logic [WIDTH_PC-1:0]  branch_offset,
  input  logic                 jump,
  input  logic [J_INDEX_W-1:0] jump_index,
  input  logic                 jr,
  input  logic [WIDTH_PC-1:0]  jr_target,
  output logic [WIDTH_PC-1:0]  pc_plus_step,
  output logic [WIDTH_PC-1:0]  next_pc,
  output logic                 jr_trap
);

  localparam logic [WIDTH_PC-1:0] ALIGN_MASK = ~WIDTH_PC'(3);

  logic jr_misaligned;

  assign pc_plus_step  = pc + WIDTH_PC'(STEP);
  assign jr_misaligned = (jr_target[1:0] != 2'b00);
  assign jr_trap       = MISALIGN_TRAP_EN && jr && jr_misaligned;

  always_comb begin
    next_pc = pc_plus_step;
    if (jr) begin
      if (jr_trap) next_pc = TRAP_VECTOR;
      else         next_pc = jr_target & ALIGN_MASK;
    end else if (jump) begin
      next_pc = {pc_plus_step[WIDTH_PC-1:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus_step + (branch_offset << 2);
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program counter sequencer: holds the fetch PC and state, applies halt/stall ahead of redirects.
// Build option: PC_MISALIGN_TRAP_EN (misaligned jr traps instead of being silently aligned).
//   state | meaning
//   BOOT  | pc = RESET_VECTOR, not yet fetching; all inputs ignored, advances sequentially into RUN
//   RUN   | fetching; pc follows next_pc unless halt_req or stall
//   HALT  | pc frozen, nothing valid; exits only through reset
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int                  WIDTH_PC     = 32,
  parameter int                  STEP         = 4,
  parameter logic [WIDTH_PC-1:0] RESET_VECTOR = WIDTH_PC'(RESET_VECTOR_DEF),
  parameter logic [WIDTH_PC-1:0] TRAP_VECTOR  = WIDTH_PC'(TRAP_VECTOR_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 halt_req,
  input  logic                 branch_taken,
  input  logic [WIDTH_PC-1:0]  branch_offset,
  input  logic                 jump,
  input  logic [J_INDEX_W-1:0] jump_index,
  input  logic                 jr,
  input  logic [WIDTH_PC-1:0]  jr_target,
  output logic [WIDTH_PC-1:0]  pc,
  output logic [WIDTH_PC-1:0]  pc_plus_step,
  output logic                 pc_valid,
  output logic                 halted,
  output logic                 trap,
  output logic [WIDTH_PC-1:0]  epc
);

  pc_state_t           state, state_nxt;
  logic [WIDTH_PC-1:0] pc_nxt, epc_nxt, calc_next_pc;
  logic                trap_nxt, jr_trap;

  pc_target_calc #(
    .WIDTH_PC    (WIDTH_PC),
    .STEP        (STEP),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_target_calc (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .pc_plus_step  (pc_plus_step),
    .next_pc       (calc_next_pc),
    .jr_trap       (jr_trap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc    <= RESET_VECTOR;
      trap  <= 1'b0;
      epc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      trap  <= trap_nxt;
      epc   <= epc_nxt;
    end
  end

  // Without the trap option jr_trap is constant 0, so trap and epc stay at their reset value.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    trap_nxt  = 1'b0;
    epc_nxt   = epc;
    pc_valid  = 1'b0;
    halted    = 1'b0;
    unique case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
        pc_nxt    = pc_plus_step;
      end
      ST_RUN: begin
        pc_valid = 1'b1;
        if (halt_req) begin
          state_nxt = ST_HALT;
        end else if (!stall) begin
          pc_nxt = calc_next_pc;
          if (jr_trap) begin
            trap_nxt = 1'b1;
            epc_nxt  = jr_target;
          end
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed table, hand sequences and randomized model check.
module tb_pc_next_unit;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TB_TRAP = 1'b1;
`else
  localparam bit TB_TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt_req, branch_taken, jump, jr;
  logic [31:0] branch_offset, jr_target;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus_step, epc;
  logic        pc_valid, halted, trap;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  logic [31:0] m_pc, m_epc;
  bit          m_run, m_halt, m_trap;

  pc_next_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .halt_req      (halt_req),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .pc            (pc),
    .pc_plus_step  (pc_plus_step),
    .pc_valid      (pc_valid),
    .halted        (halted),
    .trap          (trap),
    .epc           (epc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_run = 0; m_halt = 0; m_trap = 0;
  endtask

  task automatic model_edge(input bit s, input bit h, input bit b, input logic [31:0] off,
                            input bit j, input logic [25:0] idx, input bit r, input logic [31:0] tgt);
    logic [31:0] seq;
    seq    = m_pc + 32'd4;
    m_trap = 0;
    if (!m_run && !m_halt) begin
      m_run = 1;
      m_pc  = seq;
    end else if (m_run) begin
      if (h) begin
        m_run = 0; m_halt = 1;
      end else if (s) begin
        // hold
      end else if (r) begin
        if (TB_TRAP && (tgt % 4 != 0)) begin
          m_pc = 32'h180; m_epc = tgt; m_trap = 1;
        end else begin
          m_pc = tgt - (tgt % 4);
        end
      end else if (j) begin
        m_pc = (seq & 32'hF000_0000) + 32'(idx) * 32'd4;
      end else if (b) begin
        m_pc = seq + off * 32'd4;
      end else begin
        m_pc = seq;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},        pc,                   m_pc);
    check({tag, ".pc_plus"},   pc_plus_step,         m_pc + 32'd4);
    check({tag, ".pc_valid"},  {31'd0, pc_valid},    {31'd0, m_run});
    check({tag, ".halted"},    {31'd0, halted},      {31'd0, m_halt});
    check({tag, ".trap"},      {31'd0, trap},        {31'd0, m_trap});
    check({tag, ".epc"},       epc,                  m_epc);
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, then compare at the next falling edge.
  task automatic step(input string tag, input bit s, input bit h, input bit b, input logic [31:0] off,
                      input bit j, input logic [25:0] idx, input bit r, input logic [31:0] tgt);
    stall = s; halt_req = h; branch_taken = b; branch_offset = off;
    jump = j; jump_index = idx; jr = r; jr_target = tgt;
    @(negedge clk);
    model_edge(s, h, b, off, j, idx, r, tgt);
    check_model(tag);
  endtask

  task automatic step_idle(input string tag);
    step(tag, 0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    step("goto", 0, 0, 0, 32'h0, 0, 26'h0, 1, addr);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse(input string tag);
    stall = 0; halt_req = 0; branch_taken = 0; jump = 0; jr = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".pc"},       pc,                32'h0);
    check({tag, ".pc_valid"}, {31'd0, pc_valid}, 32'h0);
    check({tag, ".halted"},   {31'd0, halted},   32'h0);
    check({tag, ".trap"},     {31'd0, trap},     32'h0);
    check({tag, ".epc"},      epc,               32'h0);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] start;
    bit          s, b, j, r;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"branch_back",   32'h0000_0100, 0, 1, 0, 0, 32'hFFFF_FFFE, 26'h0,        32'h0,    32'h0000_00FC};
    vecs[1] = '{"jump_over_br",  32'h0000_0100, 0, 1, 1, 0, 32'hFFFF_FFFE, 26'h40,       32'h0,    32'h0000_0100};
    vecs[2] = '{"seq_wrap",      32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0,         26'h0,        32'h0,    32'h0000_0000};
    vecs[3] = '{"stall_drop_jr", 32'h0000_1000, 1, 0, 0, 1, 32'h0,         26'h0,        32'h500,  32'h0000_1000};
    vecs[4] = '{"jr_wins",       32'h0000_1000, 0, 1, 1, 1, 32'h4,         26'h7,        32'h2468, 32'h0000_2468};
    vecs[5] = '{"jump_region",   32'h8000_0010, 0, 0, 1, 0, 32'h0,         26'h3FF_FFFF, 32'h0,    32'h8FFF_FFFC};
    vecs[6] = '{"branch_wrap",   32'hFFFF_FFF8, 0, 1, 0, 0, 32'h1,         26'h0,        32'h0,    32'h0000_0000};
    vecs[7] = '{"jump_cross",    32'h0FFF_FFFC, 0, 0, 1, 0, 32'h0,         26'h5,        32'h0,    32'h1000_0014};
    vecs[8] = '{"branch_fwd",    32'h0000_2000, 0, 1, 0, 0, 32'h10,        26'h0,        32'h0,    32'h0000_2044};

    rst_n = 1'b0;
    stall = 0; halt_req = 0; branch_taken = 0; branch_offset = '0;
    jump = 0; jump_index = '0; jr = 0; jr_target = '0;
    model_reset();

    // reset state and boot sequence
    @(negedge clk);
    @(negedge clk);
    check("rst.pc",       pc,                32'h0);
    check("rst.pc_valid", {31'd0, pc_valid}, 32'h0);
    check("rst.halted",   {31'd0, halted},   32'h0);
    check("rst.trap",     {31'd0, trap},     32'h0);
    check("rst.epc",      epc,               32'h0);
    rst_n = 1'b1;
    #1;
    check("boot.pc",       pc,                32'h0);
    check("boot.pc_valid", {31'd0, pc_valid}, 32'h0);
    step_idle("boot1"); check("boot1.const", pc, 32'h4);
    step_idle("boot2"); check("boot2.const", pc, 32'h8);
    step_idle("boot3"); check("boot3.const", pc, 32'hC);
    check("boot3.valid", {31'd0, pc_valid}, 32'h1);

    // directed table
    for (int i = 0; i < 9; i++) begin
      goto_pc(vecs[i].start);
      step(vecs[i].name, vecs[i].s, 0, vecs[i].b, vecs[i].off,
           vecs[i].j, vecs[i].idx, vecs[i].r, vecs[i].tgt);
      check({vecs[i].name, ".exp"}, pc, vecs[i].exp_pc);
    end

    // misaligned register jump
    goto_pc(32'h300);
    step("mis", 0, 0, 0, 32'h0, 0, 26'h0, 1, 32'h203);
    check("mis.pc",   pc,             TB_TRAP ? 32'h180 : 32'h200);
    check("mis.trap", {31'd0, trap},  TB_TRAP ? 32'h1 : 32'h0);
    check("mis.epc",  epc,            TB_TRAP ? 32'h203 : 32'h0);
    step_idle("mis_after");
    check("mis_after.trap", {31'd0, trap}, 32'h0);
    check("mis_after.pc",   pc,            TB_TRAP ? 32'h184 : 32'h204);

    // halt, ignore redirects, leave via reset
    goto_pc(32'h20);
    step("halt", 0, 1, 0, 32'h0, 0, 26'h0, 0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      step("halt_hold", 0, 0, 1, 32'h8, 1, 26'h123, 1, 32'h444);
      check("halt_hold.pc",  pc,               32'h20);
      check("halt_hold.hlt", {31'd0, halted},  32'h1);
    end
    reset_pulse("halt_rst");
    step_idle("resume");
    check("resume.pc", pc, 32'h4);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit          s, h, b, j, r;
      logic [31:0] off, tgt;
      logic [25:0] idx;
      if (m_halt && $urandom_range(0, 7) == 0) begin
        reset_pulse("rnd_rst");
        step_idle("rnd_boot");
      end else begin
        s   = ($urandom_range(0, 3) == 0);
        h   = ($urandom_range(0, 63) == 0);
        b   = ($urandom_range(0, 2) == 0);
        j   = ($urandom_range(0, 3) == 0);
        r   = ($urandom_range(0, 3) == 0);
        off = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) - 32'd32 : 32'($urandom);
        idx = 26'($urandom);
        tgt = 32'($urandom);
        if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
        step("rnd", s, h, b, off, j, idx, r, tgt);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 Parameter WIDTH_PC, default 32: PC and address width in bits; SHALL be >= 32.
REQ-002 Parameter STEP, default 4: sequential increment in bytes.
REQ-003 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-004 Parameter TRAP_VECTOR, default 32'h0000_0180: PC value loaded on a misalignment trap.
REQ-005 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 stall  in  1  hold PC for this cycle.
REQ-008 halt_req  in  1  enter HALT at next edge.
REQ-009 branch_taken  in  1  take branch this cycle.
REQ-010 branch_offset  in  WIDTH_PC  sign-extended word offset.
REQ-011 jump  in  1  take J-type jump.
REQ-012 jump_index  in  26  J-type instruction index.
REQ-013 jr  in  1  take register jump.
REQ-014 jr_target  in  WIDTH_PC  register jump address.
REQ-015 pc  out  WIDTH_PC  current fetch address (registered).
REQ-016 pc_plus_step  out  WIDTH_PC  combinational pc + STEP.
REQ-017 pc_valid  out  1  pc is a valid fetch address.
REQ-018 halted  out  1  unit is in HALT.
REQ-019 trap  out  1  one-cycle misalignment trap pulse.
REQ-020 epc  out  WIDTH_PC  faulting jr_target captured on trap.

Function
REQ-021 States: BOOT, RUN, HALT; the state register SHALL be the only control state.
REQ-022 BOOT: pc = RESET_VECTOR, pc_valid = 0; BOOT -> RUN unconditionally at the first edge after rst_n deasserts.
REQ-023 RUN: pc_valid = 1; pc SHALL load next_pc each edge.
REQ-024 next_pc priority: halt_req > stall > jr > jump > branch_taken > sequential.
REQ-025 halt_req in RUN: pc holds and the state moves to HALT; HALT SHALL be left only by reset.
REQ-026 HALT: pc holds, pc_valid = 0, halted = 1; all redirect inputs are ignored.
REQ-027 stall: pc holds; any concurrent redirect is discarded, not queued.
REQ-028 sequential: next_pc = pc + STEP, modulo 2^WIDTH_PC (wraps to 0, no flag).
REQ-029 branch: next_pc = pc_plus_step + (branch_offset << 2), modulo 2^WIDTH_PC.
REQ-030 jump: next_pc = {pc_plus_step[WIDTH_PC-1:28], jump_index, 2'b00}.
REQ-031 jr: next_pc = jr_target, subject to REQ-036/037.
REQ-032 Redirect inputs asserted in BOOT SHALL be ignored.
REQ-033 trap SHALL be asserted for exactly one cycle and SHALL never assert without the macro.

Reset
REQ-034 rst_n low SHALL immediately force state = BOOT, pc = RESET_VECTOR, pc_valid = 0, halted = 0, trap = 0, epc = 0, independent of clk.
REQ-035 Reset asserted mid-operation, including in HALT, SHALL discard all pending behaviour.

Configuration
REQ-036 With PC_MISALIGN_TRAP_EN defined: jr with jr_target[1:0] != 0 in RUN SHALL cause next_pc = TRAP_VECTOR, epc = jr_target, and trap = 1 for the following cycle.
REQ-037 Without PC_MISALIGN_TRAP_EN: jr uses {jr_target[WIDTH_PC-1:2], 2'b00}; trap is tied 0 and epc is tied 0.

Structure
REQ-038 A shared package SHALL hold the state enumeration (BOOT/RUN/HALT), the default RESET_VECTOR and TRAP_VECTOR, and the J-type index width constant 26.
REQ-039 One sub-module, pc_target_calc, SHALL be combinational: inputs pc, redirect controls and operands; output next_pc. The state register and the PC register stay in the top.

Verification
REQ-040 Reset release, 3 idle cycles -> pc sequence 0x0 (pc_valid = 0), 0x4, 0x8, 0xC.
REQ-041 pc = 0x100, branch_taken = 1, branch_offset = 0xFFFF_FFFE -> next pc = 0xFC; with jump = 1 asserted in the same cycle, jump_index = 0x40 -> next pc = 0x100.
REQ-042 pc = 0xFFFF_FFFC, no redirect -> next pc = 0x0; stall = 1 with jr = 1 -> pc holds and jr is dropped.
REQ-043 Macro defined, jr_target = 0x203 -> next pc = 0x180, epc = 0x203, trap high for one cycle; macro undefined -> next pc = 0x200, trap = 0.
REQ-044 halt_req at pc = 0x20 -> pc stays 0x20, halted = 1, pc_valid = 0 for 10 cycles despite jump; rst_n pulse mid-clock -> pc = 0x0 immediately, then resumes at 0x4.
